hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 38 +++
 rtl/hazard_scoreboard_counter_file.sv | 50 +++++
 rtl/hazard_scoreboard.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Purpose  : Shared uop definitions for the issue scoreboard: writer-class
//            encodings, register-file geometry and countdown width.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 5;
  localparam int CNT_W    = 3;
  localparam int WCLS_W   = 2;

  // Writer class carried with each uop; code 3 is an alias for a memory writer.
  typedef enum logic [WCLS_W-1:0] {
    WCLS_NONE    = 2'd0,
    WCLS_MUL     = 2'd1,
    WCLS_MEM     = 2'd2,
    WCLS_MEM_ALT = 2'd3
  } wcls_e;

  // Countdown value loaded for a destination written by the given class.
  // ALU writers load zero, which retires any older pending long-latency write.
  function automatic logic [CNT_W-1:0] wcls_latency(input wcls_e cls,
                                                    input int    lat_mul,
                                                    input int    lat_mem);
    logic [CNT_W-1:0] lat;
    case (cls)
      WCLS_NONE: lat = '0;
      WCLS_MUL:  lat = CNT_W'(lat_mul);
      default:   lat = CNT_W'(lat_mem);
    endcase
    return lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_counter_file.sv
`default_nettype none
// ============================================================================
// Module   : sb_counter_file
// Purpose  : Per-architectural-register countdown array. Register 0 is never
//            tracked and always reads as ready.
// Revision : 1.0 - initial release
// ============================================================================
module sb_counter_file
  import hazard_scoreboard_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear_i,
  input  logic                              hold_i,
  input  logic [NUM_REGS-1:1]               load_en_i,
  input  logic [NUM_REGS-1:1][CNT_W-1:0]    load_val_i,
  output logic [NUM_REGS-1:0][CNT_W-1:0]    cnt_o
);

  logic [NUM_REGS-1:1][CNT_W-1:0] cnt_q;
  logic [NUM_REGS-1:1][CNT_W-1:0] cnt_d;

  // Next countdown per register: clear beats load, load beats decrement.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (clear_i) begin
        cnt_d[r] = '0;
      end else if (load_en_i[r]) begin
        cnt_d[r] = load_val_i[r];
      end else if (!hold_i && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  // Counter storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read port: r0 is tied to zero so lookups can index the full register space.
  assign cnt_o = {cnt_q, {CNT_W{1'b0}}};

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : In-order multi-lane issue scoreboard. Stalls the bundle on RAW
//            hazards against in-flight long-latency writers, trims the bundle
//            to a prefix on intra-bundle dependencies, and counts RAW stalls.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int LAT_MUL = 1,
  parameter int LAT_MEM = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ISSUE_W-1:0]       issue_en,
  input  logic [REG_W*ISSUE_W-1:0] issue_rj,
  input  logic [REG_W*ISSUE_W-1:0] issue_rk,
  input  logic [REG_W*ISSUE_W-1:0] issue_rd,
  input  logic [2*ISSUE_W-1:0]     issue_lat,
  input  logic                     freeze,
  input  logic                     flush,
  output logic [ISSUE_W-1:0]       issue_grant,
  output logic                     stall,
  output logic [31:0]              raw_stall_cnt
);

  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
  logic [NUM_REGS-1:1]            w_load_en;
  logic [NUM_REGS-1:1][CNT_W-1:0] w_load_val;

  logic [REG_W-1:0] w_rj  [ISSUE_W];
  logic [REG_W-1:0] w_rk  [ISSUE_W];
  logic [REG_W-1:0] w_rd  [ISSUE_W];
  wcls_e            w_cls [ISSUE_W];

  logic [ISSUE_W-1:0] w_blocked;
  logic [ISSUE_W-1:0] w_dep;
  logic [ISSUE_W-1:0] w_grant;
  logic [ISSUE_W-1:0] w_accept;
  logic               w_any_blocked;
  logic               w_stall;

  logic [31:0] raw_stall_cnt_q;
  logic [31:0] raw_stall_cnt_d;

  // Unpack the flat lane buses into per-lane fields.
  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_lane
    assign w_rj[gi]  = issue_rj[REG_W*gi +: REG_W];
    assign w_rk[gi]  = issue_rk[REG_W*gi +: REG_W];
    assign w_rd[gi]  = issue_rd[REG_W*gi +: REG_W];
    assign w_cls[gi] = wcls_e'(issue_lat[2*gi +: 2]);
  end

  // A lane is blocked when either non-zero source still has a pending write.
  always_comb begin
    w_blocked = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (issue_en[i]) begin
        w_blocked[i] = ((w_rj[i] != '0) && (w_cnt[w_rj[i]] != '0)) ||
                       ((w_rk[i] != '0) && (w_cnt[w_rk[i]] != '0));
      end
    end
  end

  // Intra-bundle dependency: an older enabled long-latency writer feeds this
  // lane. Grant is cut at the first dependent lane so issue stays in order.
  always_comb begin
    w_dep   = '0;
    w_grant = '0;
    for (int i = 1; i < ISSUE_W; i++) begin
      for (int j = 0; j < i; j++) begin
        if (issue_en[j] && (w_cls[j] != WCLS_NONE) && (w_rd[j] != '0) &&
            ((w_rd[j] == w_rj[i]) || (w_rd[j] == w_rk[i]))) begin
          w_dep[i] = 1'b1;
        end
      end
    end
    w_grant[0] = 1'b1;
    for (int i = 1; i < ISSUE_W; i++) begin
      w_grant[i] = w_grant[i-1] & ~w_dep[i];
    end
  end

  assign w_any_blocked = |w_blocked;
  assign w_stall       = freeze | w_any_blocked;
  assign w_accept      = issue_en & w_grant & {ISSUE_W{~w_stall & ~flush}};

  // Destination updates from accepted lanes; later lanes overwrite earlier
  // ones so the youngest writer of a register decides its countdown.
  always_comb begin
    w_load_en  = '0;
    w_load_val = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (w_accept[i] && (w_rd[i] != '0)) begin
        w_load_en[w_rd[i]]  = 1'b1;
        w_load_val[w_rd[i]] = wcls_latency(w_cls[i], LAT_MUL, LAT_MEM);
      end
    end
  end

  sb_counter_file u_counter_file (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (flush),
    .hold_i     (freeze),
    .load_en_i  (w_load_en),
    .load_val_i (w_load_val),
    .cnt_o      (w_cnt)
  );

  // RAW stall cycles are counted only when the backend is live and not flushing.
  always_comb begin
    raw_stall_cnt_d = raw_stall_cnt_q;
    if (!freeze && !flush && w_any_blocked) begin
      raw_stall_cnt_d = raw_stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_stall_cnt_q <= '0;
    end else begin
      raw_stall_cnt_q <= raw_stall_cnt_d;
    end
  end

  assign issue_grant   = w_grant;
  assign stall         = w_stall;
  assign raw_stall_cnt = raw_stall_cnt_q;

endmodule
`default_nettype wire
